div_fl: RTL and testbench

Fixed-latency signed radix-2 divider that complements the `multi`/`multi_vl` multipliers in the arithmetic block set. It uses the same start/valid handshake style, so the same style of self-checking bench can drive it. It accepts a 32-bit signed dividend and divisor and returns a 32-bit quotient and remainder, plus a divide-by-zero flag. The result arrives exactly WIDTH+1 cycles after a start rising edge. It is built as a restoring shift-subtract datapath controlled by a small FSM.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 27 ++
 rtl/div_fl.sv | 91 +++++++++
 tb/tb_div_fl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and the magnitude helper for the fixed-latency divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    // Two's-complement negate when neg is set; neg_if(x, x[MSB]) gives |x|.
    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] x,
                                                    input logic                 neg);
        return neg ? (~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] t;

    always_comb begin
        rq_sh  = {r, q} << 1;
        r_sh   = rq_sh[2*WIDTH:WIDTH];
        // One extra bit so a borrow shows up as a negative trial remainder.
        t      = {1'b0, r_sh} - {2'b00, d};
        r_next = t[WIDTH+1] ? r_sh : t[WIDTH:0];
        q_next = rq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~t[WIDTH+1]};
    end

endmodule

// File: rtl/div_fl.sv
// Fixed-latency signed radix-2 restoring divider; result valid WIDTH+1 cycles after start edge.
module div_fl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    input  logic                    start,
    output logic signed [WIDTH-1:0] quot,
    output logic signed [WIDTH-1:0] rem,
    output logic                    div_by_zero,
    output logic                    valid
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic             start_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] d;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    // Divide by zero must report all ones regardless of the dividend sign.
    function automatic logic [WIDTH-1:0] final_quot(input logic [WIDTH-1:0] mag,
                                                    input logic             neg,
                                                    input logic             zero_div);
        return zero_div ? '1 : neg_if(mag, neg);
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_d     <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            valid       <= 1'b0;
        end else begin
            start_d <= start;
            valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        q      <= neg_if(dividend, dividend[WIDTH-1]);
                        d      <= neg_if(divisor, divisor[WIDTH-1]);
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[WIDTH-1];
                        dz     <= (divisor == '0);
                        r      <= '0;
                        cnt    <= CNT_W'(WIDTH - 1);
                        state  <= DIV;
                    end
                end
                // ---- iterate: one quotient bit per cycle, MSB first ----
                DIV: begin
                    r <= r_next;
                    q <= q_next;
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                // ---- sign correction and result register ----
                FIX: begin
                    quot        <= final_quot(q, sign_q, dz);
                    rem         <= neg_if(r[WIDTH-1:0], sign_r);
                    div_by_zero <= dz;
                    valid       <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_fl.sv
// Directed and random self-checking bench for div_fl.
module tb_div_fl;
    import div_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic        valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    div_fl #(.WIDTH(DIV_WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .valid       (valid)
    );

    always #5 clock = ~clock;

    // Raise start with operands; returns just after the accepting edge E0, start still high.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (quot !== 32'h0) begin n_err++; $display("FAIL reset_quot got %h want %h", quot, 32'h0); end
        n_vec++;
        if (rem !== 32'h0) begin n_err++; $display("FAIL reset_rem got %h want %h", rem, 32'h0); end
        n_vec++;
        if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        reset_n = 1'b1;
    endtask

    task automatic test_hold_start;
        int lat;
        int extra;
        launch(32'd100, 32'd7);
        wait_valid(lat);
        n_vec++;
        if (lat != DIV_LATENCY) begin n_err++; $display("FAIL hold_latency got %0d want %0d", lat, DIV_LATENCY); end
        n_vec++;
        if ({quot, rem, div_by_zero} !== {32'h0000000E, 32'h00000002, 1'b0}) begin
            n_err++;
            $display("FAIL hold_result got q=%h r=%h dz=%b want q=0000000e r=00000002 dz=0", quot, rem, div_by_zero);
        end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (valid) extra++;
        end
        n_vec++;
        if (extra != 0) begin n_err++; $display("FAIL hold_single_pulse got %0d extra pulses want 0", extra); end
        start = 1'b0;
    endtask

    task automatic test_signs;
        vec_t tbl[8];
        int   lat;
        tbl[0] = '{32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        tbl[1] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
        tbl[2] = '{32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0};
        tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        tbl[4] = '{32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0};
        tbl[5] = '{32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b1};
        tbl[6] = '{32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
        tbl[7] = '{32'h00000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].a, tbl[i].b);
            start = 1'b0;
            wait_valid(lat);
            n_vec++;
            if ({quot, rem, div_by_zero} !== {tbl[i].q, tbl[i].r, tbl[i].dz}) begin
                n_err++;
                $display("FAIL signs[%0d] %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, tbl[i].a,
                         tbl[i].b, quot, rem, div_by_zero, tbl[i].q, tbl[i].r, tbl[i].dz);
            end
            n_vec++;
            if (lat != DIV_LATENCY) begin n_err++; $display("FAIL signs_latency[%0d] got %0d want %0d", i, lat, DIV_LATENCY); end
        end
    endtask

    task automatic test_retrigger;
        int pulses = 0;
        int lat = -1;
        launch(32'd200, 32'd9);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (k == 4) start = 1'b0;
            if (k == 9) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd2;
            end
            if (k == 11) start = 1'b0;
            if (valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL retrigger_pulses got %0d want 1", pulses); end
        n_vec++;
        if (lat != DIV_LATENCY) begin n_err++; $display("FAIL retrigger_latency got %0d want %0d", lat, DIV_LATENCY); end
        n_vec++;
        if ({quot, rem} !== {32'd22, 32'd2}) begin
            n_err++;
            $display("FAIL retrigger_result got q=%h r=%h want q=00000016 r=00000002", quot, rem);
        end
    endtask

    task automatic test_reset_mid;
        int          pulses = 0;
        int          lat;
        logic [31:0] q15 = 'x;
        logic [31:0] r15 = 'x;
        launch(32'd1000, 32'd3);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (k == 15) begin
                q15     = quot;
                r15     = rem;
                reset_n = 1'b1;
            end
            if (k == 14) reset_n = 1'b0;
            if (valid) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL midreset_pulses got %0d want 0", pulses); end
        n_vec++;
        if ({q15, r15} !== 64'h0) begin n_err++; $display("FAIL midreset_outputs got q=%h r=%h want 0 0", q15, r15); end
        launch(32'd1000, 32'd3);
        start = 1'b0;
        wait_valid(lat);
        n_vec++;
        if ({quot, rem, div_by_zero} !== {32'd333, 32'd1, 1'b0} || lat != DIV_LATENCY) begin
            n_err++;
            $display("FAIL midreset_next got q=%h r=%h dz=%b lat=%0d want q=0000014d r=00000001 dz=0 lat=%0d",
                     quot, rem, div_by_zero, lat, DIV_LATENCY);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic [63:0] tq;
        logic [63:0] tr;
        longint      sa;
        longint      sb;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = neg_if({16'h0, b[15:0]}, b[31]);
            if (i % 4 == 2) b = neg_if({28'h0, b[3:0]}, b[30]);
            if (i % 64 == 3) a = 32'h80000000;
            if (i % 50 == 7) b = 32'h0;
            if (i % 97 == 5) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (b == 32'h0) begin
                eq  = 32'hFFFFFFFF;
                er  = a;
                edz = 1'b1;
            end else begin
                tq  = sa / sb;
                tr  = sa % sb;
                eq  = tq[31:0];
                er  = tr[31:0];
                edz = 1'b0;
            end
            launch(a, b);
            start = 1'b0;
            wait_valid(lat);
            n_vec++;
            if ({quot, rem, div_by_zero} !== {eq, er, edz}) begin
                n_err++;
                $display("FAIL random[%0d] %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, a, b,
                         quot, rem, div_by_zero, eq, er, edz);
            end
            n_vec++;
            if (lat != DIV_LATENCY) begin n_err++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, DIV_LATENCY); end
        end
    endtask

    initial begin
        test_reset;
        test_hold_start;
        test_signs;
        test_retrigger;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
